// File: rtl/pipe_wb.sv
// pipe_wb: MIPS-style write-back stage register with HI/LO and optional retire counter
// Ports: clk, rst (async, active-low); mem_* = MEM-stage instruction fields and
// hold (freeze WB register); rf_wdata/rf_waddr/rf_wena = regfile write port;
// hi/lo = architectural HI/LO. Define WB_RETIRE_CNT_EN to add retire_cnt.
module pipe_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        hold,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_dmem_out,
  input  logic [4:0]  mem_rf_waddr,
  input  logic        mem_rf_wena,
  input  logic [2:0]  mem_rf_mux_sel,
  input  logic [1:0]  mem_load_size,
  input  logic        mem_load_sign,
  input  logic        mem_hi_wena,
  input  logic        mem_lo_wena,
  input  logic [31:0] mem_hi_wdata,
  input  logic [31:0] mem_lo_wdata,
  output logic [31:0] rf_wdata,
  output logic [4:0]  rf_waddr,
  output logic        rf_wena,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);
  logic        wb_valid, wb_wena, wb_sign, wb_hi_wena, wb_lo_wena;
  logic [31:0] wb_pc4, wb_alu, wb_dmem, wb_hi_wdata, wb_lo_wdata;
  logic [4:0]  wb_waddr;
  logic [2:0]  wb_sel;
  logic [1:0]  wb_size;
  logic [31:0] lane_word, load_data;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wb_valid    <= 1'b0;
      wb_pc4      <= '0;
      wb_alu      <= '0;
      wb_dmem     <= '0;
      wb_waddr    <= '0;
      wb_wena     <= 1'b0;
      wb_sel      <= '0;
      wb_size     <= '0;
      wb_sign     <= 1'b0;
      wb_hi_wena  <= 1'b0;
      wb_lo_wena  <= 1'b0;
      wb_hi_wdata <= '0;
      wb_lo_wdata <= '0;
    end else if (!hold) begin
      wb_valid    <= mem_valid;
      wb_pc4      <= mem_pc4;
      wb_alu      <= mem_alu_out;
      wb_dmem     <= mem_dmem_out;
      wb_waddr    <= mem_rf_waddr;
      wb_wena     <= mem_rf_wena;
      wb_sel      <= mem_rf_mux_sel;
      wb_size     <= mem_load_size;
      wb_sign     <= mem_load_sign;
      wb_hi_wena  <= mem_hi_wena;
      wb_lo_wena  <= mem_lo_wena;
      wb_hi_wdata <= mem_hi_wdata;
      wb_lo_wdata <= mem_lo_wdata;
    end

  // HI/LO rewrite every edge the instruction sits in WB, so a held write is idempotent
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (wb_valid && wb_hi_wena) hi <= wb_hi_wdata;
      if (wb_valid && wb_lo_wena) lo <= wb_lo_wdata;
    end

`ifdef WB_RETIRE_CNT_EN
  // An instruction retires at the edge where WB takes new contents
  always_ff @(posedge clk or negedge rst)
    if (!rst) retire_cnt <= '0;
    else if (!hold && wb_valid) retire_cnt <= retire_cnt + 32'd1;
`endif

  // Little-endian lane extraction
  always_comb begin
    lane_word = wb_dmem >> {wb_alu[1:0], 3'b000};
    lane_byte = lane_word[7:0];
    lane_half = wb_alu[1] ? wb_dmem[31:16] : wb_dmem[15:0];
    load_data = wb_size == 2'b10 ? {{24{wb_sign & lane_byte[7]}}, lane_byte} :
                wb_size == 2'b01 ? {{16{wb_sign & lane_half[15]}}, lane_half} : wb_dmem;
  end

  assign rf_waddr = wb_waddr;
  assign rf_wena  = wb_valid && wb_wena && (wb_waddr != 5'd0);
  assign rf_wdata = wb_sel == 3'd1 ? wb_pc4 :
                    wb_sel == 3'd2 ? hi :
                    wb_sel == 3'd3 ? lo :
                    wb_sel == 3'd4 ? load_data :
                    wb_sel == 3'd5 ? wb_alu : 32'd0;
endmodule
